tdc_readout_sched: RTL and testbench
====================================

Name: tdc_readout_sched

Overview:
Round-robin readout scheduler for the TDC channel array behind the Wishbone slave. It collects timestamps from NCHAN capture channels that each hold a result until acknowledged. Each result is tagged with its channel index and pushed into a shared show-ahead FIFO. The Wishbone register decoder drains the FIFO one entry per read strobe.

Parameters:
NCHAN, 4, number of TDC capture channels (2..8)
CW, 2, channel-index width; must equal clog2(NCHAN)
TW, 32, timestamp width per channel (coarse + fine)
AW, 3, FIFO address width; depth = 2**AW

Ports:
wb_clk_i  input  1  system clock, shared with the Wishbone slave
rst_n_i  input  1  asynchronous active-low reset
arm_i  input  NCHAN  per-channel enable mask; an unarmed channel is never granted
chan_valid_i  input  NCHAN  channel holds an unread timestamp
chan_ts_i  input  NCHAN*TW  timestamps; channel k occupies bits [k*TW +: TW]
chan_ack_o  output  NCHAN  one-cycle pulse: the channel's timestamp was taken
rd_i  input  1  pop strobe from the register decoder
rd_data_o  output  CW+TW  FIFO head, formatted {chan_idx, ts}
empty_o  output  1  FIFO empty
count_o  output  AW+1  FIFO occupancy
stall_o  output  1  sticky flag: an armed channel was pending while the FIFO was full
stall_clr_i  input  1  clears stall_o

Behaviour:
- Reset values (asynchronous, applied on the falling edge of rst_n_i): chan_ack_o=0, empty_o=1, count_o=0, stall_o=0, rd_data_o=0. Read/write pointers=0, rr_ptr=0.
- Request vector: req = chan_valid_i & arm_i & ~chan_ack_o. The channel acked in the previous cycle is masked so it cannot be granted twice.
- Grant (combinational): if count_o < 2**AW and req != 0, choose the first set bit of req searching upward from rr_ptr, with wrap.
- On the clock edge with a grant to channel g:
  - write {g, ts_g} at the write pointer;
  - chan_ack_o[g]=1 for exactly one cycle;
  - rr_ptr = g+1 mod NCHAN.
- Latency: data sampled at the grant edge; chan_ack_o high the cycle after the edge; entry visible on rd_data_o one cycle after the write, never in the same cycle.
- Channel contract: chan_valid_i and chan_ts_i stay stable until chan_ack_o. The channel deasserts valid, or presents a new value, in the cycle after the ack.
- Pop: rd_i with empty_o=0 advances the read pointer. rd_i with empty_o=1 is ignored (no pointer move, no error).
- Full condition uses the registered count only. When count_o == 2**AW, no grant is made even if rd_i is asserted in the same cycle; the grant is retried next cycle.
- Simultaneous push and pop when not full: both happen and count_o is unchanged.
- Pointers are AW bits and wrap naturally.
- rd_data_o is the registered head entry. It holds its last value when the FIFO is empty.
- stall_o is set in any cycle where the FIFO is full and (chan_valid_i & arm_i) != 0. stall_clr_i clears it; if set and clear occur together, set wins.
- Clearing arm_i[k] while channel k is pending withdraws the request; nothing already written is affected.
- Asserting rst_n_i mid-operation empties the FIFO and drops any in-flight ack. Channels keep their data and are re-granted after reset release.

Optional Feature:
TDC_SCHED_DROP_EN.
- Defined:
  - when the FIFO is full, the round-robin winner is still acked and its timestamp is discarded;
  - an extra output drop_cnt_o [7:0] counts discards, resets to 0, saturates at 255, and is cleared by stall_clr_i;
  - stall_o behaves as without the macro.
- Undefined: channels are back-pressured as above and port drop_cnt_o does not exist.

Test Plan:
- NCHAN=4, arm_i=4'hF, all valid with ts=k*16'h100 → acks in order 0,1,2,3. FIFO holds {0,0x000},{1,0x100},{2,0x200},{3,0x300}. count_o=4.
- Channel 2 alone valid, ts=0xDEAD, rd_i idle → chan_ack_o=4'b0100 for one cycle. Two cycles after the grant edge rd_data_o={2,0xDEAD} and empty_o=0.
- Fill 8 entries, channel 1 still valid → no ack, stall_o=1. One rd_i → channel 1 acked the following cycle. stall_clr_i → stall_o=0.
- rd_i pulsed while empty → count_o stays 0, pointers unchanged, rd_data_o unchanged.
- arm_i=4'b1010 with all valid → only channels 1 and 3 granted, alternating.
- rst_n_i pulsed low with 5 entries queued → count_o=0, empty_o=1, chan_ack_o=0 immediately, without waiting for a clock edge.
- TDC_SCHED_DROP_EN defined: FIFO full plus 300 acked requests → drop_cnt_o=255 and FIFO contents unchanged.

Source files
------------

// File: rtl/tdc_readout_sched.sv
// tdc_readout_sched
// Round-robin readout scheduler for the TDC capture channels. Each granted
// timestamp is tagged with its channel index and pushed into a small
// show-ahead FIFO that the Wishbone register decoder drains with rd_i.
//
// Optional build macro: TDC_SCHED_DROP_EN
//   defined   -> a full FIFO no longer back-pressures the channels; the
//                round-robin winner is still acked, its timestamp discarded
//                and counted on drop_cnt_o (saturating, cleared by stall_clr_i).
//   undefined -> channels are held off while the FIFO is full; no drop_cnt_o.
//
// Head timing: rd_data_o and empty_o are both registered from the memory as
// it stood before the current edge, so a freshly written entry reaches the
// head one cycle after its write. empty_o is derived from the same term as
// rd_data_o, which keeps the two aligned: whenever empty_o is low, rd_data_o
// already shows the entry that the next rd_i will consume.

module tdc_readout_sched #(
  parameter int NCHAN = 4,
  parameter int CW    = 2,
  parameter int TW    = 32,
  parameter int AW    = 3
) (
  input  logic                wb_clk_i,
  input  logic                rst_n_i,
  input  logic [NCHAN-1:0]    arm_i,
  input  logic [NCHAN-1:0]    chan_valid_i,
  input  logic [NCHAN*TW-1:0] chan_ts_i,
  output logic [NCHAN-1:0]    chan_ack_o,
  input  logic                rd_i,
  output logic [CW+TW-1:0]    rd_data_o,
  output logic                empty_o,
  output logic [AW:0]         count_o,
  output logic                stall_o,
  input  logic                stall_clr_i
`ifdef TDC_SCHED_DROP_EN
  ,
  output logic [7:0]          drop_cnt_o
`endif
);

  localparam int            DW       = CW + TW;
  localparam int            DEPTH    = 1 << AW;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  // arbitration
  logic [NCHAN-1:0] req;
  logic             win_vld;
  logic [CW-1:0]    win_idx;
  logic [CW:0]      cand;

  // flops
  logic [NCHAN-1:0] ack_q, ack_d;
  logic [CW-1:0]    rr_q, rr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             empty_q, empty_d;
  logic [DW-1:0]    rd_data_q, rd_data_d;
  logic             stall_q, stall_d;

  // fifo control
  logic             full;
  logic             push;
  logic             pop;
  logic             take;
  logic [AW:0]      rem;
  logic [DW-1:0]    wr_data;

  logic [DW-1:0]    mem_q [DEPTH];

  // Round-robin search: first requesting channel at or above rr_q, with wrap.
  // The channel acked last cycle is masked because its valid is still high
  // during the ack cycle.
  always_comb begin
    req     = chan_valid_i & arm_i & ~ack_q;
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = 0; i < NCHAN; i++) begin
      cand = {1'b0, rr_q} + (CW+1)'(i);
      if (cand >= (CW+1)'(NCHAN)) begin
        cand = cand - (CW+1)'(NCHAN);
      end
      if (!win_vld && req[cand[CW-1:0]]) begin
        win_vld = 1'b1;
        win_idx = cand[CW-1:0];
      end
    end
  end

  // Grant qualification, ack generation and the next round-robin origin.
  always_comb begin
    full = (count_q == FULL_CNT);
    push = win_vld & ~full;
`ifdef TDC_SCHED_DROP_EN
    take = win_vld;
`else
    take = push;
`endif
    ack_d = take ? (NCHAN'(1) << win_idx) : '0;
    rr_d  = rr_q;
    if (take) begin
      rr_d = (win_idx == CW'(NCHAN-1)) ? '0 : win_idx + CW'(1);
    end
    wr_data = {win_idx, chan_ts_i[int'(win_idx)*TW +: TW]};
  end

  // FIFO pointers, occupancy and the registered show-ahead head.
  always_comb begin
    pop      = rd_i & ~empty_q;
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
    rem      = count_q - (AW+1)'(pop);
    empty_d  = (rem == '0);
    rd_data_d = (rem != '0) ? mem_q[rd_ptr_d] : rd_data_q;
  end

  // Sticky stall: any armed pending channel while full; set beats clear.
  always_comb begin
    stall_d = (full && ((chan_valid_i & arm_i) != '0)) | (stall_q & ~stall_clr_i);
  end

  // Control and head registers.
  always_ff @(posedge wb_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ack_q     <= '0;
      rr_q      <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      empty_q   <= 1'b1;
      rd_data_q <= '0;
      stall_q   <= 1'b0;
    end else begin
      ack_q     <= ack_d;
      rr_q      <= rr_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      empty_q   <= empty_d;
      rd_data_q <= rd_data_d;
      stall_q   <= stall_d;
    end
  end

  // Storage array; contents are only meaningful below the occupancy count.
  always_ff @(posedge wb_clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

`ifdef TDC_SCHED_DROP_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  // Saturating count of winners discarded because the FIFO was full.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (stall_clr_i) begin
      drop_cnt_d = '0;
    end else if (win_vld && full && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  // Drop counter register.
  always_ff @(posedge wb_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt_o = drop_cnt_q;
`endif

  assign chan_ack_o = ack_q;
  assign rd_data_o  = rd_data_q;
  assign empty_o    = empty_q;
  assign count_o    = count_q;
  assign stall_o    = stall_q;

endmodule

// File: tb/tb_tdc_readout_sched.sv
// Directed bench for tdc_readout_sched (NCHAN=4, TW=32, AW=3).
// A tiny channel model inside tick() drops a channel's valid one cycle after
// its ack when auto_clr is set; otherwise channels keep presenting data.

module tb_tdc_readout_sched;
  localparam int NCHAN = 4;
  localparam int CW    = 2;
  localparam int TW    = 32;
  localparam int AW    = 3;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NCHAN-1:0]    arm;
  logic [NCHAN-1:0]    valid;
  logic [NCHAN*TW-1:0] ts;
  logic [NCHAN-1:0]    ack;
  logic                rd;
  logic [CW+TW-1:0]    rd_data;
  logic                empty;
  logic [AW:0]         count;
  logic                stall;
  logic                stall_clr;
`ifdef TDC_SCHED_DROP_EN
  logic [7:0]          drop_cnt;
`endif

  logic [NCHAN-1:0]    prev_ack;
  logic                auto_clr;
  int                  n_cmp = 0;
  int                  n_fail = 0;

  tdc_readout_sched #(.NCHAN(NCHAN), .CW(CW), .TW(TW), .AW(AW)) dut (
    .wb_clk_i     (clk),
    .rst_n_i      (rst_n),
    .arm_i        (arm),
    .chan_valid_i (valid),
    .chan_ts_i    (ts),
    .chan_ack_o   (ack),
    .rd_i         (rd),
    .rd_data_o    (rd_data),
    .empty_o      (empty),
    .count_o      (count),
    .stall_o      (stall),
    .stall_clr_i  (stall_clr)
`ifdef TDC_SCHED_DROP_EN
    ,
    .drop_cnt_o   (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_clr) valid = valid & ~prev_ack;
    prev_ack = ack;
  endtask

  task automatic fill8(input logic [31:0] base);
    logic got;
    for (int i = 0; i < 8; i++) begin
      ts[31:0] = base + 32'(i);
      valid[0] = 1'b1;
      got = 1'b0;
      for (int t = 0; t < 10 && !got; t++) begin
        tick();
        if (ack[0]) got = 1'b1;
      end
      n_cmp++;
      if (got !== 1'b1) begin
        n_fail++;
        $display("FAIL fill_ack[%0d]: ack seen=%0b required=1", i, got);
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; arm = '0; valid = '0; ts = '0; rd = 1'b0; stall_clr = 1'b0;
    auto_clr = 1'b1; prev_ack = '0;
    #12;
    n_cmp++; if (ack !== 4'b0)   begin n_fail++; $display("FAIL reset_ack: got %b required 0000", ack); end
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b required 1", empty); end
    n_cmp++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d required 0", count); end
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b required 0", stall); end
    n_cmp++; if (rd_data !== 34'd0) begin n_fail++; $display("FAIL reset_rd_data: got %h required 0", rd_data); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [33:0] exp;
    arm = 4'hF;
    for (int k = 0; k < NCHAN; k++) ts[k*TW +: TW] = 32'(k * 32'h100);
    valid = 4'hF;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (ack !== (4'b1 << i)) begin n_fail++; $display("FAIL rr_ack[%0d]: got %b required %b", i, ack, 4'b1 << i); end
    end
    tick();
    n_cmp++; if (ack !== 4'b0)   begin n_fail++; $display("FAIL rr_ack_idle: got %b required 0000", ack); end
    n_cmp++; if (count !== 4'd4) begin n_fail++; $display("FAIL rr_count: got %0d required 4", count); end
    for (int i = 0; i < 4; i++) begin
      exp = {2'(i), 32'(i * 32'h100)};
      n_cmp++;
      if (empty !== 1'b0 || rd_data !== exp) begin
        n_fail++; $display("FAIL rr_pop[%0d]: got empty=%b data=%h required empty=0 data=%h", i, empty, rd_data, exp);
      end
      rd = 1'b1; tick(); rd = 1'b0;
    end
    n_cmp++; if (empty !== 1'b1 || count !== 4'd0) begin n_fail++; $display("FAIL rr_drained: got empty=%b count=%0d required 1/0", empty, count); end
  endtask

  task automatic test_latency();
    ts[2*TW +: TW] = 32'hDEAD;
    valid = 4'b0100;
    tick();
    n_cmp++; if (ack !== 4'b0100) begin n_fail++; $display("FAIL lat_ack: got %b required 0100", ack); end
    n_cmp++; if (empty !== 1'b1)  begin n_fail++; $display("FAIL lat_same_cycle_empty: got %b required 1", empty); end
    tick();
    n_cmp++; if (ack !== 4'b0) begin n_fail++; $display("FAIL lat_ack_pulse: got %b required 0000", ack); end
    tick();
    n_cmp++;
    if (empty !== 1'b0 || rd_data !== {2'd2, 32'hDEAD}) begin
      n_fail++; $display("FAIL lat_head: got empty=%b data=%h required empty=0 data=%h", empty, rd_data, {2'd2, 32'hDEAD});
    end
    rd = 1'b1; tick(); rd = 1'b0;
  endtask

  task automatic test_full_stall();
    logic [33:0] exp;
    fill8(32'h1000);
    n_cmp++; if (count !== 4'd8) begin n_fail++; $display("FAIL full_count: got %0d required 8", count); end
    ts[1*TW +: TW] = 32'hBEEF;
    valid[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (ack !== 4'b0) begin n_fail++; $display("FAIL full_no_ack[%0d]: got %b required 0000", i, ack); end
    end
    n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL full_stall: got %b required 1", stall); end
    rd = 1'b1; tick(); rd = 1'b0;
    n_cmp++; if (ack !== 4'b0 || count !== 4'd7) begin n_fail++; $display("FAIL full_pop_edge: got ack=%b count=%0d required 0000/7", ack, count); end
    tick();
    n_cmp++; if (ack !== 4'b0010 || count !== 4'd8) begin n_fail++; $display("FAIL full_retry: got ack=%b count=%0d required 0010/8", ack, count); end
    tick();
    stall_clr = 1'b1; tick(); stall_clr = 1'b0;
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL stall_clear: got %b required 0", stall); end
    for (int i = 0; i < 8; i++) begin
      exp = (i < 7) ? {2'd0, 32'h1001 + 32'(i)} : {2'd1, 32'hBEEF};
      n_cmp++;
      if (empty !== 1'b0 || rd_data !== exp) begin
        n_fail++; $display("FAIL full_drain[%0d]: got empty=%b data=%h required empty=0 data=%h", i, empty, rd_data, exp);
      end
      rd = 1'b1; tick(); rd = 1'b0;
    end
    n_cmp++; if (count !== 4'd0) begin n_fail++; $display("FAIL full_drain_count: got %0d required 0", count); end
  endtask

  task automatic test_pop_empty();
    logic [33:0] held;
    logic        got;
    held = rd_data;
    rd = 1'b1; tick(); tick(); tick(); rd = 1'b0;
    n_cmp++; if (count !== 4'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL empty_pop_state: got count=%0d empty=%b required 0/1", count, empty); end
    n_cmp++; if (rd_data !== held) begin n_fail++; $display("FAIL empty_pop_hold: got %h required %h", rd_data, held); end
    ts[3*TW +: TW] = 32'h55;
    valid = 4'b1000;
    got = 1'b0;
    for (int t = 0; t < 10 && !got; t++) begin tick(); if (ack[3]) got = 1'b1; end
    n_cmp++; if (got !== 1'b1) begin n_fail++; $display("FAIL empty_push_ack: seen=%b required 1", got); end
    tick();
    n_cmp++;
    if (empty !== 1'b0 || rd_data !== {2'd3, 32'h55} || count !== 4'd1) begin
      n_fail++; $display("FAIL empty_ptr: got empty=%b data=%h count=%0d required 0/%h/1", empty, rd_data, count, {2'd3, 32'h55});
    end
    rd = 1'b1; tick(); rd = 1'b0;
  endtask

  task automatic test_arm_mask();
    logic [3:0]  exp_ack;
    logic [33:0] exp;
    auto_clr = 1'b0;
    arm = 4'b1010;
    for (int k = 0; k < NCHAN; k++) ts[k*TW +: TW] = 32'hA0 + 32'(k);
    valid = 4'hF;
    for (int i = 0; i < 6; i++) begin
      tick();
      exp_ack = (i % 2 == 0) ? 4'b0010 : 4'b1000;
      n_cmp++; if (ack !== exp_ack) begin n_fail++; $display("FAIL arm_ack[%0d]: got %b required %b", i, ack, exp_ack); end
    end
    valid = '0;
    tick();
    n_cmp++; if (count !== 4'd6) begin n_fail++; $display("FAIL arm_count: got %0d required 6", count); end
    for (int i = 0; i < 6; i++) begin
      exp = (i % 2 == 0) ? {2'd1, 32'hA1} : {2'd3, 32'hA3};
      n_cmp++;
      if (rd_data !== exp) begin n_fail++; $display("FAIL arm_drain[%0d]: got %h required %h", i, rd_data, exp); end
      rd = 1'b1; tick(); rd = 1'b0;
    end
  endtask

  task automatic test_async_reset();
    valid = 4'hF;
    arm = 4'b1010;
    for (int i = 0; i < 5; i++) tick();
    n_cmp++; if (count !== 4'd5 || ack !== 4'b0010) begin n_fail++; $display("FAIL rst_pre: got count=%0d ack=%b required 5/0010", count, ack); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (count !== 4'd0) begin n_fail++; $display("FAIL rst_async_count: got %0d required 0", count); end
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rst_async_empty: got %b required 1", empty); end
    n_cmp++; if (ack !== 4'b0)   begin n_fail++; $display("FAIL rst_async_ack: got %b required 0000", ack); end
    @(posedge clk);
    #3 rst_n = 1'b1;
    prev_ack = '0;
    tick();
    n_cmp++; if (ack !== 4'b0010) begin n_fail++; $display("FAIL rst_regrant: got %b required 0010", ack); end
    valid = '0;
    arm = 4'hF;
    tick();
    n_cmp++; if (count !== 4'd1 || rd_data !== {2'd1, 32'hA1}) begin n_fail++; $display("FAIL rst_after: got count=%0d data=%h required 1/%h", count, rd_data, {2'd1, 32'hA1}); end
    rd = 1'b1; tick(); rd = 1'b0;
    auto_clr = 1'b1;
  endtask

`ifdef TDC_SCHED_DROP_EN
  task automatic test_drop();
    int n_ack;
    fill8(32'h2000);
    auto_clr = 1'b0;
    arm = 4'hF;
    valid = 4'hF;
    n_ack = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (ack != 4'b0) n_ack++;
    end
    valid = '0;
    tick();
    if (ack != 4'b0) n_ack++;
    n_cmp++; if (n_ack !== 300)      begin n_fail++; $display("FAIL drop_acks: got %0d required 300", n_ack); end
    n_cmp++; if (drop_cnt !== 8'd255) begin n_fail++; $display("FAIL drop_cnt_sat: got %0d required 255", drop_cnt); end
    n_cmp++; if (count !== 4'd8)     begin n_fail++; $display("FAIL drop_count: got %0d required 8", count); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (rd_data !== {2'd0, 32'h2000 + 32'(i)}) begin n_fail++; $display("FAIL drop_contents[%0d]: got %h required %h", i, rd_data, {2'd0, 32'h2000 + 32'(i)}); end
      rd = 1'b1; tick(); rd = 1'b0;
    end
    stall_clr = 1'b1; tick(); stall_clr = 1'b0;
    n_cmp++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL drop_clr: got %0d required 0", drop_cnt); end
    auto_clr = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_latency();
    test_full_stall();
    test_pop_empty();
    test_arm_mask();
    test_async_reset();
`ifdef TDC_SCHED_DROP_EN
    test_drop();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
